// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding scoreboard.
// The slot record holds only what bypass and hazard decisions need.
package fwd_pkg;

  // The rd field is sized for the widest supported register file.
  // Narrower register addresses are zero-extended into it.
  localparam int unsigned RD_MAX_W   = 8;
  localparam int unsigned MAX_SLOTS  = 16;
  localparam int unsigned FWD_SEL_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                regwrite;
    logic                is_load;
  } slot_t;

  // A slot can supply a value only if it really writes a register other than r0.
  function automatic logic slot_live(input slot_t s);
    return s.valid && s.regwrite && (s.rd != '0);
  endfunction

  // Returns the lowest set index at or above 1, which is the youngest producer.
  // Bit 0 is the consumer itself and is never a source.
  function automatic int unsigned youngest_match(input logic [MAX_SLOTS-1:0] hit);
    youngest_match = FWD_SEL_RF;
    for (int unsigned k = MAX_SLOTS - 1; k >= 1; k--) begin
      if (hit[k]) youngest_match = k;
    end
  endfunction

endpackage

// File: rtl/fwd_operand_match.sv
// Per-operand compare against all tracked slots.
// Produces the EX bypass select and the ID load-use hazard for one source operand.
module fwd_operand_match
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned SELW       = 2
) (
  input  slot_t             slots [STAGES],
  input  logic [REG_AW-1:0] ex_rs,
  input  logic              ex_used,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              id_used,
  output logic [SELW-1:0]   sel,
  output logic              load_hazard
);

  logic [RD_MAX_W-1:0]  ex_rs_x;
  logic [RD_MAX_W-1:0]  id_rs_x;
  logic [MAX_SLOTS-1:0] hit;

  assign ex_rs_x = RD_MAX_W'(ex_rs);
  assign id_rs_x = RD_MAX_W'(id_rs);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    hit         = '0;
    load_hazard = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k >= 1 && ex_used && slot_live(slots[k]) && slots[k].rd == ex_rs_x)
        hit[k] = 1'b1;
      // A load in slot j reaches the consumer's EX at slot j+1; too early to bypass there.
      if (id_used && slot_live(slots[k]) && slots[k].is_load &&
          slots[k].rd == id_rs_x && (k + 1) < LOAD_STAGE)
        load_hazard = 1'b1;
    end
  end

  assign sel = SELW'(youngest_match(hit));

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand bypass select and load-use stall unit for an N-stage in-order pipeline.
// Define FWD_SCOREBOARD_STATS_EN to add saturating stall/forward event counters.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int unsigned REG_AW     = 5,
  parameter  int unsigned NUM_SRC    = 2,
  parameter  int unsigned STAGES     = 3,
  parameter  int unsigned LOAD_STAGE = 2,
  localparam int unsigned SELW       = $clog2(STAGES)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic [REG_AW-1:0]         id_rd_i,
  input  logic                      id_regwrite_i,
  input  logic                      id_is_load_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic [NUM_SRC*SELW-1:0]   ex_fwd_sel_o,
  output logic [NUM_SRC*REG_AW-1:0] ex_rs_o
`ifdef FWD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               fwd_cnt_o
`endif
);

  if (STAGES < 2 || STAGES > MAX_SLOTS || LOAD_STAGE < 1 || LOAD_STAGE >= STAGES ||
      REG_AW > RD_MAX_W) begin : g_bad_cfg
    $error("fwd_scoreboard: unsupported parameter combination");
  end

  slot_t                     slots [STAGES];
  slot_t                     id_entry;
  logic [NUM_SRC*REG_AW-1:0] ex_rs_q;
  logic [NUM_SRC-1:0]        ex_used_q;
  logic [NUM_SRC-1:0]        hazard;
  logic                      bubble;

  assign id_entry = '{valid: 1'b1, rd: RD_MAX_W'(id_rd_i),
                      regwrite: id_regwrite_i, is_load: id_is_load_i};

  assign stall_o = id_valid_i && !flush_i && (|hazard);
  assign bubble  = stall_o || flush_i || !id_valid_i;
  assign ex_rs_o = ex_rs_q;

  // Slot 0 is the instruction now in EX; each edge ages every entry by one slot.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned k = 0; k < STAGES; k++) slots[k] <= '0;
      ex_rs_q   <= '0;
      ex_used_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every slot read its neighbour's pre-edge value, giving a true shift.
      slots[0] <= bubble ? slot_t'('0) : id_entry;
      for (int unsigned k = 1; k < STAGES; k++) slots[k] <= slots[k-1];
      ex_rs_q   <= bubble ? '0 : id_rs_i;
      ex_used_q <= bubble ? '0 : id_rs_used_i;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_operand_match #(
      .REG_AW     (REG_AW),
      .STAGES     (STAGES),
      .LOAD_STAGE (LOAD_STAGE),
      .SELW       (SELW)
    ) u_match (
      .slots       (slots),
      .ex_rs       (ex_rs_q[i*REG_AW +: REG_AW]),
      .ex_used     (ex_used_q[i]),
      .id_rs       (id_rs_i[i*REG_AW +: REG_AW]),
      .id_used     (id_rs_used_i[i]),
      .sel         (ex_fwd_sel_o[i*SELW +: SELW]),
      .load_hazard (hazard[i])
    );
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      fwd_cnt_o   <= '0;
    end else begin
      if (stall_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
      if ((|ex_fwd_sel_o) && fwd_cnt_o != '1) fwd_cnt_o <= fwd_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised operand-bypass and hazard unit for the N-stage in-order pipeline; successor to the fixed two-source EX forwarding logic.
- Tracks the destination register and write state of every in-flight instruction in an internal shift pipeline, so stage-register fields no longer have to be fed in from outside.
- Drives per-operand bypass selects for EX and a load-use stall for ID.
- Sits beside the ID/EX pipeline registers and drives the EX operand muxes and the PC/IF-ID write enables.

Parameters:
- REG_AW, 5, register address width; register 0 is hardwired zero and is never forwarded.
- NUM_SRC, 2, source operands per instruction.
- STAGES, 3, tracked slots after ID. Slot 0 = EX, 1 = MEM, 2 = WB, and so on; min 2.
- LOAD_STAGE, 2, first slot from which load data is forwardable; 1 <= LOAD_STAGE < STAGES.
- SELW, $clog2(STAGES), bypass select width; derived, not overridable.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_i  in  NUM_SRC*REG_AW  ID source registers; operand i is at [i*REG_AW +: REG_AW].
- id_rs_used_i  in  NUM_SRC  operand i is actually read.
- id_rd_i  in  REG_AW  ID destination register.
- id_regwrite_i  in  1  ID instruction writes rd.
- id_is_load_i  in  1  ID instruction is a load.
- flush_i  in  1  squash the ID instruction (branch taken).
- stall_o  out  1  hold PC and IF/ID, insert a bubble into EX.
- ex_fwd_sel_o  out  NUM_SRC*SELW  per EX operand: 0 = register file, k = bypass from slot k.
- ex_rs_o  out  NUM_SRC*REG_AW  registered EX source registers, for debug and mux alignment.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Slot state, per slot: valid, rd, regwrite, is_load.
- Reset (rst_i = 0, async):
  - all slot valid bits 0;
  - ex_rs_o = 0, internal EX used bits = 0;
  - ex_fwd_sel_o = 0, stall_o = 0.
  - Reset mid-operation drops all in-flight entries; nothing is forwarded after release.
- Every rising clock edge (no enable):
  - slot[k] <= slot[k-1] for k >= 1;
  - slot[0] <= the ID entry, or a bubble (valid = 0) when stall_o = 1, flush_i = 1 or id_valid_i = 0;
  - ex_rs_o and the EX used bits capture id_rs_i / id_rs_used_i on the same condition, and are zeroed on a bubble.
- Live entry: valid and regwrite and rd != 0.
- ex_fwd_sel_o[i]:
  - combinational from registered state only; no ID inputs reach it;
  - equals the smallest k in 1..STAGES-1 where slot[k] is live and slot[k].rd == ex_rs[i] and EX used[i], else 0;
  - the youngest producer wins;
  - a load in slot k < LOAD_STAGE never appears as a select; the stall guarantees this case cannot occur.
- stall_o, combinational, is 1 when all of the following hold:
  - id_valid_i = 1 and flush_i = 0;
  - some operand i has id_rs_used_i[i] = 1;
  - some slot j is live with is_load, slot[j].rd == id_rs[i], and j + 1 < LOAD_STAGE.
  - Default parameters: stall only for a load sitting in EX, for exactly 1 cycle.
  - Upstream holds the ID inputs while stall_o = 1; the bubble lets the load advance, then stall_o deasserts.
- Simultaneous events:
  - flush_i masks stall_o;
  - ID rd == EX rs is irrelevant, because ID is younger;
  - duplicate operands (rs0 == rs1) get identical selects.
- Latency: stall_o is 0-cycle combinational; the bypass select for an instruction is valid in the cycle it occupies EX.

Optional Feature:
- FWD_SCOREBOARD_STATS_EN defined:
  - adds outputs stall_cnt_o [31:0] and fwd_cnt_o [31:0];
  - stall_cnt_o increments each cycle stall_o = 1;
  - fwd_cnt_o increments each cycle any ex_fwd_sel_o field is nonzero;
  - both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fwd_pkg:
  - slot entry struct {valid, rd, regwrite, is_load};
  - FWD_SEL_RF = 0 constant;
  - a function computing the youngest-match index.
- Sub-module fwd_operand_match: one instance per source operand (NUM_SRC instances). It takes the slot array plus one rs/used pair and returns the select and a load-hazard flag.

Test Plan:
- Default parameters. add r3 in MEM; EX instruction reads r3 as rs0 -> ex_fwd_sel_o[rs0] = 1, rs1 = 0.
- r3 written in both MEM (newer) and WB; EX reads r3 on both operands -> both selects = 1; after one more cycle with MEM now holding r5 -> both selects = 2.
- lw r4 in EX; ID reads r4 -> stall_o = 1 for exactly 1 cycle, EX gets a bubble, next cycle ex_fwd_sel_o[rs0] = 2 (load now in WB).
- Writes to r0, or regwrite = 0, matching an EX source -> select = 0; the same cases in ID against a load -> stall_o = 0.
- Load-use stall with flush_i = 1 in the same cycle -> stall_o = 0 and slot 0 is a bubble. Asserting rst_i low mid-stream -> all selects = 0 and stall_o = 0 immediately.
- STAGES = 5, LOAD_STAGE = 3, NUM_SRC = 3: a load in slot 1 matching an ID operand -> stall_o = 1 (1 + 1 < 3); the same load in slot 2 -> stall_o = 0 and, once the consumer is in EX, its select = 3.
